i2c_target: RTL and testbench

- Responder end of the two-wire serial bus driven by the existing master state machine (START, address, ACK, data, STOP).
- Oversamples SCL/SDA with the system clock and detects START/STOP.
- Matches a 7-bit address and acknowledges it; receives write bytes and supplies read bytes.
- Sits beside the master on the shared open-drain bus; drives SDA low only through sda_oe.

---
 rtl/i2c_target_pkg.sv | 19 +
 rtl/i2c_line_sync.sv | 51 +++++
 rtl/i2c_target.sv | 168 ++++++++++++++++
 tb/tb_i2c_target.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_target_pkg.sv
// Shared types and bus constants for the I2C target.
package i2c_target_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_WRITE,
        S_WR_ACK,
        S_READ,
        S_RD_ACK,
        S_IGNORE
    } state_t;

    localparam logic ACK     = 1'b0;
    localparam logic NACK    = 1'b1;
    localparam logic RW_READ = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizers with registered edge, START and STOP pulses.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda
);

    logic [SYNC_STAGES-1:0] scl_s;
    logic [SYNC_STAGES-1:0] sda_s;
    logic                   scl_q;
    logic                   sda_q;
    logic                   scl_n;
    logic                   sda_n;

    assign scl_n = scl_s[SYNC_STAGES-1];
    assign sda_n = sda_s[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_s     <= '1;
            sda_s     <= '1;
            scl_q     <= 1'b1;
            sda_q     <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            scl_s     <= {scl_s[SYNC_STAGES-2:0], scl_in};
            sda_s     <= {sda_s[SYNC_STAGES-2:0], sda_in};
            scl_q     <= scl_n;
            sda_q     <= sda_n;
            scl_rise  <= scl_n & ~scl_q;
            scl_fall  <= ~scl_n & scl_q;
            start_det <= scl_n & scl_q & sda_q & ~sda_n;
            stop_det  <= scl_n & scl_q & ~sda_q & sda_n;
        end
    end

    // Aligned with the registered pulses above
    assign sda = sda_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target: address match, write receive, read transmit.
module i2c_target
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] ADDR        = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy
);

    logic       scl_rise;
    logic       scl_fall;
    logic       start_det;
    logic       stop_det;
    logic       sda;

    state_t     state;
    logic [2:0] cnt;
    logic [7:0] shreg;
    logic [7:0] txsh;
    logic       rw;
    logic       ackon;

    i2c_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det),
        .sda      (sda)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= 3'd0;
            shreg    <= 8'd0;
            txsh     <= 8'd0;
            rw       <= 1'b0;
            ackon    <= 1'b0;
            sda_oe   <= 1'b0;
            rx_data  <= 8'd0;
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            if (stop_det) begin
                state  <= S_IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
                ackon  <= 1'b0;
            end else if (start_det) begin
                state  <= S_ADDR;
                cnt    <= 3'd0;
                sda_oe <= 1'b0;
                ackon  <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: ;
                    S_ADDR: if (scl_rise) begin
                        shreg <= {shreg[6:0], sda};
                        cnt   <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            if (shreg[6:0] == ADDR) begin
                                state <= S_ADDR_ACK;
                                rw    <= sda;
                                ackon <= 1'b0;
                                busy  <= 1'b1;
                            end else begin
                                state <= S_IGNORE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    S_ADDR_ACK: if (scl_fall) begin
                        if (!ackon) begin
                            sda_oe <= 1'b1;
                            ackon  <= 1'b1;
                            if (rw == RW_READ) begin
                                txsh   <= tx_data;
                                tx_req <= 1'b1;
                            end
                        end else begin
                            ackon <= 1'b0;
                            cnt   <= 3'd0;
                            if (rw == RW_READ) begin
                                state  <= S_READ;
                                sda_oe <= ~txsh[7];
                            end else begin
                                state  <= S_WRITE;
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    S_WRITE: if (scl_rise) begin
                        shreg <= {shreg[6:0], sda};
                        cnt   <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            rx_data  <= {shreg[6:0], sda};
                            rx_valid <= 1'b1;
                            ackon    <= 1'b0;
                            state    <= S_WR_ACK;
                        end
                    end
                    S_WR_ACK: if (scl_fall) begin
                        if (!ackon) begin
                            sda_oe <= 1'b1;
                            ackon  <= 1'b1;
                        end else begin
                            sda_oe <= 1'b0;
                            ackon  <= 1'b0;
                            cnt    <= 3'd0;
                            state  <= S_WRITE;
                        end
                    end
                    S_READ: if (scl_fall) begin
                        if (cnt == 3'd7) begin
                            sda_oe <= 1'b0;
                            ackon  <= 1'b0;
                            state  <= S_RD_ACK;
                        end else begin
                            sda_oe <= ~txsh[6];
                            txsh   <= {txsh[6:0], 1'b0};
                            cnt    <= cnt + 3'd1;
                        end
                    end
                    S_RD_ACK: begin
                        // Master's ACK is sampled first; bit7 goes out on the fall after it
                        if (scl_rise && !ackon) begin
                            if (sda == ACK) begin
                                txsh   <= tx_data;
                                tx_req <= 1'b1;
                                ackon  <= 1'b1;
                            end else begin
                                state <= S_IGNORE;
                                busy  <= 1'b0;
                            end
                        end else if (scl_fall && ackon) begin
                            sda_oe <= ~txsh[7];
                            cnt    <= 3'd0;
                            ackon  <= 1'b0;
                            state  <= S_READ;
                        end
                    end
                    S_IGNORE: sda_oe <= 1'b0;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Directed and randomized bus transactions against a transaction-level model.
module tb_i2c_target;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_req;
    logic       busy;

    assign sda_in = sda_m & ~sda_oe;

    i2c_target #(
        .ADDR       (7'h42),
        .SYNC_STAGES(2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .scl_in  (scl_m),
        .sda_in  (sda_in),
        .sda_oe  (sda_oe),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .tx_data (tx_data),
        .tx_req  (tx_req),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] rx_mon[$];
    logic [7:0] exp_rx[$];
    int         txreq_cnt = 0;
    int         oe_cnt = 0;

    always @(negedge clk) begin
        if (rx_valid) rx_mon.push_back(rx_data);
        if (tx_req) txreq_cnt++;
        if (sda_oe) oe_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic addr_ack(input logic [6:0] a);
        return a == 7'h42;
    endfunction

    task automatic check_rx(input string tag);
        chk({tag, "_rxcount"}, rx_mon.size(), exp_rx.size());
        if (rx_mon.size() == exp_rx.size())
            for (int i = 0; i < exp_rx.size(); i++)
                chk({tag, "_rxbyte"}, rx_mon[i], exp_rx[i]);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; #50;
        scl_m = 1'b1; #50;
        sda_m = 1'b0; #50;
        scl_m = 1'b0; #50;
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; #50;
        scl_m = 1'b1; #50;
        sda_m = 1'b1; #100;
    endtask

    task automatic bus_bit(input logic b, output logic s);
        sda_m = b;    #50;
        scl_m = 1'b1; #50;
        s = sda_in;   #50;
        scl_m = 1'b0; #50;
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
        bus_bit(1'b1, s);
        acked = (s == 1'b0);
    endtask

    task automatic rd_byte(input logic mack, input logic [7:0] nxt,
                           output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            d[i] = s;
        end
        tx_data = nxt;
        bus_bit(mack ? 1'b0 : 1'b1, s);
    endtask

    task automatic rand_txn();
        logic [6:0] a;
        logic       rd;
        int         n;
        int         t0;
        logic       ak;
        logic [7:0] d;
        logic [7:0] q[$];
        a  = ($urandom_range(0, 1) == 1) ? 7'h42 : 7'($urandom);
        rd = 1'($urandom_range(0, 1));
        n  = $urandom_range(1, 3);
        t0 = txreq_cnt;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        tx_data = q[0];
        bus_start();
        wr_byte({a, rd}, ak);
        chk("rnd_addr_ack", ak, addr_ack(a));
        chk("rnd_busy", busy, addr_ack(a));
        if (rd && addr_ack(a)) begin
            for (int i = 0; i < n; i++) begin
                rd_byte(i < n - 1, (i < n - 1) ? q[i+1] : 8'($urandom), d);
                chk("rnd_rd_data", d, q[i]);
            end
            chk("rnd_rd_oe_after_nack", sda_oe, 1'b0);
            chk("rnd_rd_busy_after_nack", busy, 1'b0);
        end else if (!rd) begin
            for (int i = 0; i < n; i++) begin
                wr_byte(q[i], ak);
                chk("rnd_wr_ack", ak, addr_ack(a));
                if (addr_ack(a)) exp_rx.push_back(q[i]);
            end
        end
        bus_stop();
        chk("rnd_busy_stop", busy, 1'b0);
        chk("rnd_txreq", txreq_cnt - t0, (rd && addr_ack(a)) ? n : 0);
        check_rx("rnd");
    endtask

    initial begin
        logic       ak;
        logic       s;
        logic [7:0] d;
        int         t0;
        int         o0;

        #100;
        chk("rst_sda_oe", sda_oe, 1'b0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_tx_req", tx_req, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        #100;

        // single write
        bus_start();
        wr_byte(8'h84, ak);
        chk("wr_addr_ack", ak, 1'b1);
        chk("wr_busy", busy, 1'b1);
        wr_byte(8'hA5, ak);
        chk("wr_data_ack", ak, 1'b1);
        exp_rx.push_back(8'hA5);
        bus_stop();
        chk("wr_busy_stop", busy, 1'b0);
        chk("wr_rx_data", rx_data, 8'hA5);
        check_rx("wr");

        // address mismatch
        o0 = oe_cnt;
        bus_start();
        wr_byte(8'h86, ak);
        chk("mm_addr_ack", ak, 1'b0);
        chk("mm_busy", busy, 1'b0);
        wr_byte(8'hFF, ak);
        chk("mm_data_ack", ak, 1'b0);
        bus_stop();
        chk("mm_oe_never", oe_cnt - o0, 0);
        check_rx("mm");

        // general call is not ours
        bus_start();
        wr_byte(8'h00, ak);
        chk("gc_ack", ak, 1'b0);
        bus_stop();

        // read two bytes
        tx_data = 8'h3C;
        t0 = txreq_cnt;
        bus_start();
        wr_byte(8'h85, ak);
        chk("rd_addr_ack", ak, 1'b1);
        rd_byte(1'b1, 8'h81, d);
        chk("rd_byte0", d, 8'h3C);
        rd_byte(1'b0, 8'h00, d);
        chk("rd_byte1", d, 8'h81);
        chk("rd_oe_nack", sda_oe, 1'b0);
        chk("rd_busy_nack", busy, 1'b0);
        bus_stop();
        chk("rd_txreq", txreq_cnt - t0, 2);

        // write then repeated START into a read
        bus_start();
        wr_byte(8'h84, ak);
        wr_byte(8'h11, ak);
        exp_rx.push_back(8'h11);
        tx_data = 8'h5A;
        bus_start();
        chk("rs_busy_held", busy, 1'b1);
        wr_byte(8'h85, ak);
        chk("rs_addr_ack", ak, 1'b1);
        rd_byte(1'b0, 8'h00, d);
        chk("rs_rd_byte", d, 8'h5A);
        bus_stop();
        chk("rs_rx_data", rx_data, 8'h11);
        check_rx("rs");

        // STOP mid-byte
        bus_start();
        wr_byte(8'h84, ak);
        for (int i = 0; i < 4; i++) bus_bit(1'(i), s);
        bus_stop();
        chk("mid_busy", busy, 1'b0);
        chk("mid_oe", sda_oe, 1'b0);
        check_rx("mid");
        bus_start();
        wr_byte(8'h84, ak);
        chk("mid_next_ack", ak, 1'b1);
        wr_byte(8'h3F, ak);
        exp_rx.push_back(8'h3F);
        bus_stop();
        check_rx("mid_next");

        // START/STOP pair with no clock, then a normal write
        sda_m = 1'b0; #100;
        sda_m = 1'b1; #100;
        chk("ss_busy", busy, 1'b0);
        bus_start();
        wr_byte(8'h84, ak);
        chk("ss_next_ack", ak, 1'b1);
        wr_byte(8'hC3, ak);
        exp_rx.push_back(8'hC3);
        bus_stop();
        check_rx("ss");

        // reset while ACKing the address
        bus_start();
        for (int i = 7; i >= 0; i--) bus_bit(1'((8'h84 >> i) & 1), s);
        #20;
        chk("rsa_oe_before", sda_oe, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rsa_oe", sda_oe, 1'b0);
        chk("rsa_busy", busy, 1'b0);
        chk("rsa_rx_data", rx_data, 8'h00);
        chk("rsa_rx_valid", rx_valid, 1'b0);
        chk("rsa_tx_req", tx_req, 1'b0);
        scl_m = 1'b1;
        sda_m = 1'b1;
        #100;
        rst_n = 1'b1;
        #100;

        for (int k = 0; k < 16; k++) rand_txn();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
